debounce_bank: RTL

//  N-channel parametrised debouncer for push-buttons/switches. Successor to the single-channel debouncer.

---
 rtl/debounce_pkg.sv | 16 +
 rtl/debounce_channel.sv | 161 ++++++++++++++++
 rtl/debounce_bank.sv | 38 +++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and default timing constants for the debounce bank.
// DEBOUNCE_LONGPRESS_EN (see debounce_channel) enables long-press detection.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_REL = 2'd0,
    CHK_PRS  = 2'd1,
    IDLE_PRS = 2'd2,
    CHK_REL  = 2'd3
  } db_state_t;

  // 10 ms stable time and 1 s long-press at 50 MHz
  localparam int unsigned DEF_STABLE_CYCLES = 32'd500000;
  localparam int unsigned DEF_LONG_CYCLES   = 32'd50000000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: synchroniser, stable-time FSM, press/release pulses.
// Long-press hold counter is built only when DEBOUNCE_LONGPRESS_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic button_in,
  output logic db_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // The sample that makes the count reach STABLE_CYCLES completes the check
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sample_s;
  logic                   active_s;
  db_state_t              state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic                   db_r, db_s;
  logic                   press_r, press_s;
  logic                   release_r, release_s;

  // Synchroniser chain for the asynchronous pin
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], button_in};
    end
  end

  assign sample_s = sync_r[SYNC_STAGES-1];
  assign active_s = (sample_s != RESET_VAL);

  // FSM state, stable counter, debounced level and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE_REL;
      cnt_r     <= CNT_ZERO;
      db_r      <= RESET_VAL;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      db_r      <= db_s;
      press_r   <= press_s;
      release_r <= release_s;
    end
  end

  // Next-state, counter and pulse decode
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    db_s      = db_r;
    press_s   = 1'b0;
    release_s = 1'b0;
    case (state_r)
      IDLE_REL: begin
        db_s = RESET_VAL;
        if (active_s) begin
          state_s = CHK_PRS;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      CHK_PRS: begin
        if (!active_s) begin
          state_s = IDLE_REL;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r >= CNT_LAST) begin
          state_s = IDLE_PRS;
          cnt_s   = CNT_ZERO;
          db_s    = ~RESET_VAL;
          press_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      IDLE_PRS: begin
        db_s = ~RESET_VAL;
        if (!active_s) begin
          state_s = CHK_REL;
          cnt_s   = CNT_ONE;
        end else begin
          cnt_s = CNT_ZERO;
        end
      end
      CHK_REL: begin
        if (active_s) begin
          state_s = IDLE_PRS;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r >= CNT_LAST) begin
          state_s   = IDLE_REL;
          cnt_s     = CNT_ZERO;
          db_s      = RESET_VAL;
          release_s = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE_REL;
        cnt_s   = CNT_ZERO;
        db_s    = RESET_VAL;
      end
    endcase
  end

  assign db_out        = db_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_r;
  logic              long_r;

  // Hold counter runs while the debounced level is active and saturates
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_r <= HOLD_ZERO;
      long_r <= 1'b0;
    end else if ((state_r == IDLE_PRS) || (state_r == CHK_REL)) begin
      if (hold_r != HOLD_MAX) begin
        hold_r <= hold_r + HOLD_ONE;
      end else begin
        hold_r <= hold_r;
      end
      long_r <= (hold_r == HOLD_LAST);
    end else begin
      hold_r <= HOLD_ZERO;
      long_r <= 1'b0;
    end
  end

  assign long_pulse = long_r;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// N-channel debouncer: parameter pass-through and one debounce_channel per input.
// Long-press detection is enabled by defining DEBOUNCE_LONGPRESS_EN.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic        RESET_VAL     = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button_in,
  output logic [N_CH-1:0] db_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .RESET_VAL     (RESET_VAL)
    ) u_ch (
      .clk           (clk),
      .reset         (reset),
      .button_in     (button_in[i]),
      .db_out        (db_out[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule
